mem_arbiter: RTL and testbench

MEM_ARBITER -- requirements
Module: mem_arbiter

---
 rtl/mem_arb_pkg.sv | 30 +++
 rtl/mem_arbiter_if.sv | 59 +++++
 rtl/mem_addr_decode.sv | 24 ++
 rtl/mem_arbiter.sv | 151 +++++++++++++++
 tb/tb_mem_arbiter.sv | 220 ++++++++++++++++++++++
 5 files changed

// File: rtl/mem_arb_pkg.sv
// Shared types and default address map for the two-host memory arbiter.
package mem_arb_pkg;

  typedef enum logic [1:0] {
    TGT_SRAM,
    TGT_HWREG,
    TGT_NONE
  } tgt_e;

  typedef enum logic {
    HOST_INSTR,
    HOST_DATA
  } host_e;

  typedef struct packed {
    logic  valid;
    host_e host;
    tgt_e  tgt;
  } rsp_t;

  localparam logic [31:0] DEF_MEM_START  = 32'h0000_0000;
  localparam logic [31:0] DEF_MEM_MASK   = 32'h0003_FFFF;
  localparam logic [15:0] DEF_HWREG_BASE = 16'hFF00;

  // Counter must hold 0..limit and never collapse to zero width.
  function automatic int cnt_width(input int limit);
    return (limit < 1) ? 1 : $clog2(limit + 1);
  endfunction

endpackage

// File: rtl/mem_arbiter_if.sv
// Host and target bus bundle of the memory arbiter; suffixes are from the arbiter's view.
// Handshake: a host request is accepted in the cycle its gnt is high (combinational with req);
// exactly one cycle later rvalid pulses with rdata/err. Targets see a one-cycle req and answer
// with rvalid in the following cycle; there is no back-pressure anywhere.
interface mem_arbiter_if;
  logic        instr_req_i;
  logic [31:0] instr_addr_i;
  logic        instr_gnt_o;
  logic        instr_rvalid_o;
  logic        instr_err_o;
  logic [31:0] instr_rdata_o;

  logic        data_req_i;
  logic        data_we_i;
  logic [3:0]  data_be_i;
  logic [31:0] data_addr_i;
  logic [31:0] data_wdata_i;
  logic        data_gnt_o;
  logic        data_rvalid_o;
  logic        data_err_o;
  logic [31:0] data_rdata_o;

  logic        sram_req_o;
  logic        sram_we_o;
  logic [3:0]  sram_be_o;
  logic [31:0] sram_addr_o;
  logic [31:0] sram_wdata_o;
  logic        sram_rvalid_i;
  logic [31:0] sram_rdata_i;

  logic        hwreg_req_o;
  logic        hwreg_we_o;
  logic [15:0] hwreg_addr_o;
  logic [31:0] hwreg_wdata_o;
  logic        hwreg_rvalid_i;
  logic [31:0] hwreg_rdata_i;

  modport slave (
    input  instr_req_i, instr_addr_i,
    output instr_gnt_o, instr_rvalid_o, instr_err_o, instr_rdata_o,
    input  data_req_i, data_we_i, data_be_i, data_addr_i, data_wdata_i,
    output data_gnt_o, data_rvalid_o, data_err_o, data_rdata_o,
    output sram_req_o, sram_we_o, sram_be_o, sram_addr_o, sram_wdata_o,
    input  sram_rvalid_i, sram_rdata_i,
    output hwreg_req_o, hwreg_we_o, hwreg_addr_o, hwreg_wdata_o,
    input  hwreg_rvalid_i, hwreg_rdata_i
  );

  modport master (
    output instr_req_i, instr_addr_i,
    input  instr_gnt_o, instr_rvalid_o, instr_err_o, instr_rdata_o,
    output data_req_i, data_we_i, data_be_i, data_addr_i, data_wdata_i,
    input  data_gnt_o, data_rvalid_o, data_err_o, data_rdata_o,
    input  sram_req_o, sram_we_o, sram_be_o, sram_addr_o, sram_wdata_o,
    output sram_rvalid_i, sram_rdata_i,
    input  hwreg_req_o, hwreg_we_o, hwreg_addr_o, hwreg_wdata_o,
    output hwreg_rvalid_i, hwreg_rdata_i
  );
endinterface

// File: rtl/mem_addr_decode.sv
// Maps a host address onto SRAM, the hardware-register window, or nothing.
module mem_addr_decode
  import mem_arb_pkg::*;
#(
  parameter logic [31:0] MEM_START   = DEF_MEM_START,
  parameter logic [31:0] MEM_MASK    = DEF_MEM_MASK,
  parameter logic [15:0] HWREG_BASE  = DEF_HWREG_BASE,
  parameter bit          ALLOW_HWREG = 1'b1
) (
  input  logic [31:0] addr_i,
  output tgt_e        tgt_o
);

  // SRAM wins if a misconfigured map lets the two windows overlap.
  always_comb begin
    tgt_o = TGT_NONE;
    if ((addr_i & ~MEM_MASK) == MEM_START) begin
      tgt_o = TGT_SRAM;
    end else if (ALLOW_HWREG && (addr_i[31:16] == HWREG_BASE)) begin
      tgt_o = TGT_HWREG;
    end
  end

endmodule

// File: rtl/mem_arbiter.sv
// Two-host (fetch, load/store) arbiter onto SRAM and a hardware-register window,
// with a fetch starvation guard and a single-cycle response pipeline.
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter logic [31:0] MEM_START    = DEF_MEM_START,
  parameter logic [31:0] MEM_MASK     = DEF_MEM_MASK,
  parameter logic [15:0] HWREG_BASE   = DEF_HWREG_BASE,
  parameter int          STARVE_LIMIT = 4
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  mem_arbiter_if.slave      bus,
  output logic [7:0]        starve_cnt_o
);

  localparam int CNT_W = cnt_width(STARVE_LIMIT);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STARVE_LIMIT);

  tgt_e instr_tgt;
  tgt_e data_tgt;

  mem_addr_decode #(
    .MEM_START  (MEM_START),
    .MEM_MASK   (MEM_MASK),
    .HWREG_BASE (HWREG_BASE),
    .ALLOW_HWREG(1'b0)
  ) u_instr_dec (
    .addr_i(bus.instr_addr_i),
    .tgt_o (instr_tgt)
  );

  mem_addr_decode #(
    .MEM_START  (MEM_START),
    .MEM_MASK   (MEM_MASK),
    .HWREG_BASE (HWREG_BASE),
    .ALLOW_HWREG(1'b1)
  ) u_data_dec (
    .addr_i(bus.data_addr_i),
    .tgt_o (data_tgt)
  );

  logic [CNT_W-1:0] cnt_q, cnt_d;
  rsp_t             rsp_q, rsp_d;

  logic        force_instr;
  logic        instr_gnt;
  logic        data_gnt;
  logic        any_gnt;
  host_e       sel_host;
  tgt_e        sel_tgt;
  logic [31:0] sel_addr;
  logic [31:0] sel_wdata;
  logic [3:0]  sel_be;
  logic        sel_we;

  // Grants are gated by rst_ni so nothing is accepted while reset is held.
  assign force_instr = (STARVE_LIMIT != 0) && (cnt_q == CNT_MAX);
  assign instr_gnt   = rst_ni && bus.instr_req_i && (!bus.data_req_i || force_instr);
  assign data_gnt    = rst_ni && bus.data_req_i && !instr_gnt;
  assign any_gnt     = instr_gnt || data_gnt;

  always_comb begin
    sel_host  = HOST_INSTR;
    sel_tgt   = instr_tgt;
    sel_addr  = bus.instr_addr_i;
    sel_wdata = 32'h0;
    sel_be    = 4'hF;
    sel_we    = 1'b0;
    if (data_gnt) begin
      sel_host  = HOST_DATA;
      sel_tgt   = data_tgt;
      sel_addr  = bus.data_addr_i;
      sel_wdata = bus.data_wdata_i;
      sel_be    = bus.data_be_i;
      sel_we    = bus.data_we_i;
    end
  end

  assign bus.instr_gnt_o   = instr_gnt;
  assign bus.data_gnt_o    = data_gnt;

  assign bus.sram_req_o    = any_gnt && (sel_tgt == TGT_SRAM);
  assign bus.sram_we_o     = sel_we;
  assign bus.sram_be_o     = sel_be;
  assign bus.sram_addr_o   = sel_addr;
  assign bus.sram_wdata_o  = sel_wdata;

  assign bus.hwreg_req_o   = any_gnt && (sel_tgt == TGT_HWREG);
  assign bus.hwreg_we_o    = sel_we;
  assign bus.hwreg_addr_o  = sel_addr[15:0];
  assign bus.hwreg_wdata_o = sel_wdata;

  always_comb begin
    cnt_d = cnt_q;
    if (instr_gnt) begin
      cnt_d = '0;
    end else if (bus.instr_req_i && (cnt_q != CNT_MAX)) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_comb begin
    rsp_d.valid = any_gnt;
    rsp_d.host  = sel_host;
    rsp_d.tgt   = sel_tgt;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q <= '0;
      rsp_q <= '{valid: 1'b0, host: HOST_INSTR, tgt: TGT_NONE};
    end else begin
      cnt_q <= cnt_d;
      rsp_q <= rsp_d;
    end
  end

  assign starve_cnt_o = 8'(cnt_q);

  logic [31:0] rsp_rdata;
  logic        rsp_err;

  // A target rvalid only matters while a captured response is live.
  always_comb begin
    rsp_rdata = 32'h0;
    rsp_err   = 1'b1;
    unique case (rsp_q.tgt)
      TGT_SRAM: begin
        rsp_rdata = bus.sram_rdata_i;
        rsp_err   = !bus.sram_rvalid_i;
      end
      TGT_HWREG: begin
        rsp_rdata = bus.hwreg_rdata_i;
        rsp_err   = !bus.hwreg_rvalid_i;
      end
      default: begin
        rsp_rdata = 32'h0;
        rsp_err   = 1'b1;
      end
    endcase
  end

  assign bus.instr_rvalid_o = rsp_q.valid && (rsp_q.host == HOST_INSTR);
  assign bus.data_rvalid_o  = rsp_q.valid && (rsp_q.host == HOST_DATA);
  assign bus.instr_err_o    = bus.instr_rvalid_o && rsp_err;
  assign bus.data_err_o     = bus.data_rvalid_o && rsp_err;
  assign bus.instr_rdata_o  = rsp_rdata;
  assign bus.data_rdata_o   = rsp_rdata;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: decode, responses, starvation rotation and reset behaviour.
module tb_mem_arbiter;

  logic       clk_i = 1'b0;
  logic       rst_ni = 1'b0;
  logic [7:0] starve_cnt_o;
  int         n_total = 0;
  int         n_bad = 0;

  mem_arbiter_if bus();

  mem_arbiter #(.STARVE_LIMIT(4)) dut (
    .clk_i       (clk_i),
    .rst_ni      (rst_ni),
    .bus         (bus.slave),
    .starve_cnt_o(starve_cnt_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic idle_inputs();
    bus.instr_req_i    = 1'b0;
    bus.instr_addr_i   = 32'h0;
    bus.data_req_i     = 1'b0;
    bus.data_we_i      = 1'b0;
    bus.data_be_i      = 4'h0;
    bus.data_addr_i    = 32'h0;
    bus.data_wdata_i   = 32'h0;
    bus.sram_rvalid_i  = 1'b0;
    bus.sram_rdata_i   = 32'h0;
    bus.hwreg_rvalid_i = 1'b0;
    bus.hwreg_rdata_i  = 32'h0;
  endtask

  task automatic next_cycle();
    @(posedge clk_i);
    #1;
  endtask

  task automatic sample();
    @(negedge clk_i);
  endtask

  task automatic test_reset();
    rst_ni = 1'b0;
    bus.instr_req_i = 1'b1; bus.instr_addr_i = 32'h100;
    bus.data_req_i = 1'b1;  bus.data_addr_i = 32'hFF00_0000;
    bus.sram_rvalid_i = 1'b1; bus.hwreg_rvalid_i = 1'b1;
    next_cycle();
    sample();
    n_total++; if (bus.instr_gnt_o !== 1'b0) begin n_bad++; $display("FAIL rst_instr_gnt got=%b exp=0", bus.instr_gnt_o); end
    n_total++; if (bus.data_gnt_o !== 1'b0) begin n_bad++; $display("FAIL rst_data_gnt got=%b exp=0", bus.data_gnt_o); end
    n_total++; if (bus.sram_req_o !== 1'b0) begin n_bad++; $display("FAIL rst_sram_req got=%b exp=0", bus.sram_req_o); end
    n_total++; if (bus.hwreg_req_o !== 1'b0) begin n_bad++; $display("FAIL rst_hwreg_req got=%b exp=0", bus.hwreg_req_o); end
    n_total++; if (bus.instr_rvalid_o !== 1'b0) begin n_bad++; $display("FAIL rst_instr_rvalid got=%b exp=0", bus.instr_rvalid_o); end
    n_total++; if (bus.data_rvalid_o !== 1'b0) begin n_bad++; $display("FAIL rst_data_rvalid got=%b exp=0", bus.data_rvalid_o); end
    n_total++; if ({bus.instr_err_o, bus.data_err_o} !== 2'b00) begin n_bad++; $display("FAIL rst_err got=%b exp=00", {bus.instr_err_o, bus.data_err_o}); end
    n_total++; if (starve_cnt_o !== 8'd0) begin n_bad++; $display("FAIL rst_cnt got=%0d exp=0", starve_cnt_o); end
    idle_inputs();
    next_cycle();
    rst_ni = 1'b1;
  endtask

  // Runs in the first cycle after reset release, so it also covers the first-grant timing.
  task automatic test_instr_read();
    bus.instr_req_i = 1'b1; bus.instr_addr_i = 32'h0000_0100;
    sample();
    n_total++; if (bus.instr_gnt_o !== 1'b1) begin n_bad++; $display("FAIL ird_gnt got=%b exp=1", bus.instr_gnt_o); end
    n_total++; if (bus.sram_req_o !== 1'b1) begin n_bad++; $display("FAIL ird_sram_req got=%b exp=1", bus.sram_req_o); end
    n_total++; if (bus.hwreg_req_o !== 1'b0) begin n_bad++; $display("FAIL ird_hwreg_req got=%b exp=0", bus.hwreg_req_o); end
    n_total++; if (bus.sram_we_o !== 1'b0) begin n_bad++; $display("FAIL ird_we got=%b exp=0", bus.sram_we_o); end
    n_total++; if (bus.sram_be_o !== 4'hF) begin n_bad++; $display("FAIL ird_be got=%h exp=f", bus.sram_be_o); end
    n_total++; if (bus.sram_addr_o !== 32'h100) begin n_bad++; $display("FAIL ird_addr got=%h exp=00000100", bus.sram_addr_o); end
    next_cycle();
    bus.instr_req_i = 1'b0;
    bus.sram_rvalid_i = 1'b1; bus.sram_rdata_i = 32'hDEAD_BEEF;
    sample();
    n_total++; if (bus.instr_rvalid_o !== 1'b1) begin n_bad++; $display("FAIL ird_rvalid got=%b exp=1", bus.instr_rvalid_o); end
    n_total++; if (bus.instr_rdata_o !== 32'hDEAD_BEEF) begin n_bad++; $display("FAIL ird_rdata got=%h exp=deadbeef", bus.instr_rdata_o); end
    n_total++; if (bus.instr_err_o !== 1'b0) begin n_bad++; $display("FAIL ird_err got=%b exp=0", bus.instr_err_o); end
    n_total++; if (bus.data_rvalid_o !== 1'b0) begin n_bad++; $display("FAIL ird_data_rvalid got=%b exp=0", bus.data_rvalid_o); end
    next_cycle();
    idle_inputs();
  endtask

  task automatic test_hwreg_write();
    bus.data_req_i = 1'b1; bus.data_we_i = 1'b1; bus.data_be_i = 4'h3;
    bus.data_addr_i = 32'hFF00_0000; bus.data_wdata_i = 32'h41;
    sample();
    n_total++; if (bus.data_gnt_o !== 1'b1) begin n_bad++; $display("FAIL hw_gnt got=%b exp=1", bus.data_gnt_o); end
    n_total++; if (bus.hwreg_req_o !== 1'b1) begin n_bad++; $display("FAIL hw_req got=%b exp=1", bus.hwreg_req_o); end
    n_total++; if (bus.sram_req_o !== 1'b0) begin n_bad++; $display("FAIL hw_sram_req got=%b exp=0", bus.sram_req_o); end
    n_total++; if (bus.hwreg_addr_o !== 16'h0000) begin n_bad++; $display("FAIL hw_addr got=%h exp=0000", bus.hwreg_addr_o); end
    n_total++; if (bus.hwreg_we_o !== 1'b1) begin n_bad++; $display("FAIL hw_we got=%b exp=1", bus.hwreg_we_o); end
    n_total++; if (bus.hwreg_wdata_o !== 32'h41) begin n_bad++; $display("FAIL hw_wdata got=%h exp=00000041", bus.hwreg_wdata_o); end
    next_cycle();
    idle_inputs();
    bus.hwreg_rvalid_i = 1'b1;
    sample();
    n_total++; if (bus.data_rvalid_o !== 1'b1) begin n_bad++; $display("FAIL hw_rvalid got=%b exp=1", bus.data_rvalid_o); end
    n_total++; if (bus.data_err_o !== 1'b0) begin n_bad++; $display("FAIL hw_err got=%b exp=0", bus.data_err_o); end
    next_cycle();
    idle_inputs();
  endtask

  task automatic test_none_read();
    bus.data_req_i = 1'b1; bus.data_addr_i = 32'h8000_0000;
    sample();
    n_total++; if (bus.data_gnt_o !== 1'b1) begin n_bad++; $display("FAIL none_gnt got=%b exp=1", bus.data_gnt_o); end
    n_total++; if ({bus.sram_req_o, bus.hwreg_req_o} !== 2'b00) begin n_bad++; $display("FAIL none_tgt_req got=%b exp=00", {bus.sram_req_o, bus.hwreg_req_o}); end
    next_cycle();
    idle_inputs();
    bus.sram_rvalid_i = 1'b1; bus.sram_rdata_i = 32'h1234_5678;
    sample();
    n_total++; if (bus.data_rvalid_o !== 1'b1) begin n_bad++; $display("FAIL none_rvalid got=%b exp=1", bus.data_rvalid_o); end
    n_total++; if (bus.data_err_o !== 1'b1) begin n_bad++; $display("FAIL none_err got=%b exp=1", bus.data_err_o); end
    n_total++; if (bus.data_rdata_o !== 32'h0) begin n_bad++; $display("FAIL none_rdata got=%h exp=00000000", bus.data_rdata_o); end
    next_cycle();
    idle_inputs();
  endtask

  task automatic test_fetch_hwreg();
    bus.instr_req_i = 1'b1; bus.instr_addr_i = 32'hFF00_0004;
    sample();
    n_total++; if (bus.instr_gnt_o !== 1'b1) begin n_bad++; $display("FAIL fhw_gnt got=%b exp=1", bus.instr_gnt_o); end
    n_total++; if ({bus.sram_req_o, bus.hwreg_req_o} !== 2'b00) begin n_bad++; $display("FAIL fhw_tgt_req got=%b exp=00", {bus.sram_req_o, bus.hwreg_req_o}); end
    next_cycle();
    idle_inputs();
    bus.hwreg_rvalid_i = 1'b1;
    sample();
    n_total++; if (bus.instr_rvalid_o !== 1'b1) begin n_bad++; $display("FAIL fhw_rvalid got=%b exp=1", bus.instr_rvalid_o); end
    n_total++; if (bus.instr_err_o !== 1'b1) begin n_bad++; $display("FAIL fhw_err got=%b exp=1", bus.instr_err_o); end
    next_cycle();
    idle_inputs();
  endtask

  task automatic test_missing_and_stray_rvalid();
    bus.data_req_i = 1'b1; bus.data_addr_i = 32'h0000_0200;
    next_cycle();
    idle_inputs();
    sample();
    n_total++; if ({bus.data_rvalid_o, bus.data_err_o} !== 2'b11) begin n_bad++; $display("FAIL miss_rv_err got=%b exp=11", {bus.data_rvalid_o, bus.data_err_o}); end
    next_cycle();
    bus.sram_rvalid_i = 1'b1; bus.hwreg_rvalid_i = 1'b1;
    sample();
    n_total++; if ({bus.instr_rvalid_o, bus.data_rvalid_o, bus.instr_err_o, bus.data_err_o} !== 4'b0000) begin
      n_bad++; $display("FAIL stray_rvalid got=%b exp=0000", {bus.instr_rvalid_o, bus.data_rvalid_o, bus.instr_err_o, bus.data_err_o});
    end
    next_cycle();
    idle_inputs();
  endtask

  task automatic test_back_to_back_starve();
    bit         exp_instr[10] = '{0, 0, 0, 0, 1, 0, 0, 0, 0, 1};
    logic [7:0] exp_cnt[10]   = '{0, 1, 2, 3, 4, 0, 1, 2, 3, 4};
    logic [31:0] exp_addr;
    bus.data_req_i = 1'b1;  bus.data_addr_i = 32'h0000_0300;
    bus.instr_req_i = 1'b1; bus.instr_addr_i = 32'h0000_0400;
    bus.sram_rvalid_i = 1'b1; bus.sram_rdata_i = 32'h0000_0055;
    for (int i = 0; i < 10; i++) begin
      sample();
      exp_addr = exp_instr[i] ? 32'h400 : 32'h300;
      n_total++; if (bus.instr_gnt_o !== exp_instr[i]) begin n_bad++; $display("FAIL rr_instr_gnt[%0d] got=%b exp=%b", i, bus.instr_gnt_o, exp_instr[i]); end
      n_total++; if (bus.data_gnt_o !== !exp_instr[i]) begin n_bad++; $display("FAIL rr_data_gnt[%0d] got=%b exp=%b", i, bus.data_gnt_o, !exp_instr[i]); end
      n_total++; if (starve_cnt_o !== exp_cnt[i]) begin n_bad++; $display("FAIL rr_cnt[%0d] got=%0d exp=%0d", i, starve_cnt_o, exp_cnt[i]); end
      n_total++; if (bus.sram_addr_o !== exp_addr) begin n_bad++; $display("FAIL rr_addr[%0d] got=%h exp=%h", i, bus.sram_addr_o, exp_addr); end
      if (i > 0) begin
        n_total++; if (bus.instr_rvalid_o !== exp_instr[i-1]) begin n_bad++; $display("FAIL rr_instr_rvalid[%0d] got=%b exp=%b", i, bus.instr_rvalid_o, exp_instr[i-1]); end
        n_total++; if (bus.data_rvalid_o !== !exp_instr[i-1]) begin n_bad++; $display("FAIL rr_data_rvalid[%0d] got=%b exp=%b", i, bus.data_rvalid_o, !exp_instr[i-1]); end
      end
      next_cycle();
    end
    bus.instr_req_i = 1'b0; bus.data_req_i = 1'b0;
    sample();
    n_total++; if ({bus.instr_rvalid_o, bus.data_rvalid_o} !== 2'b10) begin n_bad++; $display("FAIL rr_last_rvalid got=%b exp=10", {bus.instr_rvalid_o, bus.data_rvalid_o}); end
    n_total++; if (starve_cnt_o !== 8'd0) begin n_bad++; $display("FAIL rr_cnt_end got=%0d exp=0", starve_cnt_o); end
    next_cycle();
    idle_inputs();
  endtask

  task automatic test_reset_mid();
    bus.data_req_i = 1'b1;  bus.data_addr_i = 32'h0000_0300;
    bus.instr_req_i = 1'b1; bus.instr_addr_i = 32'h0000_0400;
    next_cycle();
    sample();
    n_total++; if (starve_cnt_o !== 8'd1) begin n_bad++; $display("FAIL rm_cnt_pre got=%0d exp=1", starve_cnt_o); end
    n_total++; if (bus.data_gnt_o !== 1'b1) begin n_bad++; $display("FAIL rm_gnt got=%b exp=1", bus.data_gnt_o); end
    next_cycle();
    idle_inputs();
    bus.sram_rvalid_i = 1'b1;
    rst_ni = 1'b0;
    sample();
    n_total++; if ({bus.instr_rvalid_o, bus.data_rvalid_o} !== 2'b00) begin n_bad++; $display("FAIL rm_rvalid_in_rst got=%b exp=00", {bus.instr_rvalid_o, bus.data_rvalid_o}); end
    n_total++; if (starve_cnt_o !== 8'd0) begin n_bad++; $display("FAIL rm_cnt_in_rst got=%0d exp=0", starve_cnt_o); end
    next_cycle();
    rst_ni = 1'b1;
    for (int i = 0; i < 3; i++) begin
      sample();
      n_total++; if ({bus.instr_rvalid_o, bus.data_rvalid_o} !== 2'b00) begin n_bad++; $display("FAIL rm_rvalid_post[%0d] got=%b exp=00", i, {bus.instr_rvalid_o, bus.data_rvalid_o}); end
      n_total++; if (starve_cnt_o !== 8'd0) begin n_bad++; $display("FAIL rm_cnt_post[%0d] got=%0d exp=0", i, starve_cnt_o); end
      next_cycle();
    end
    idle_inputs();
  endtask

  initial begin
    idle_inputs();
    test_reset();
    test_instr_read();
    test_hwreg_write();
    test_none_read();
    test_fetch_hwreg();
    test_missing_and_stray_rvalid();
    test_back_to_back_starve();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
